// File: rtl/inst_fetch_ctrl.sv
// Fetch-request sequencer between preIF/IF and an sram-like instruction port.
// Latency: addr_ok at t, data_ok at t+k (k>=1) -> inst_valid at t+k+1 (no bypass).
// Backpressure: credit-gated issue; req drops while live+buffered+cancelled reaches OST_MAX.
//
// Ports:
//   clk, resetn                      clock, asynchronous active-low reset
//   pc_req_valid/addr/ready          fetch address from preIF; ready = req && addr_ok
//   flush                            redirect: cancel every fetch not yet delivered to IF
//   inst_valid/pc/rdata, inst_ready  buffered {pc, word} toward IF, popped on valid && ready
//   inst_sram_*                      sram-like read port (in-order data_ok, no backpressure)
module inst_fetch_ctrl #(
   parameter int OST_MAX = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        pc_req_valid,
   input  logic [31:0] pc_req_addr,
   output logic        pc_req_ready,
   input  logic        flush,
   output logic        inst_valid,
   output logic [31:0] inst_pc,
   output logic [31:0] inst_rdata,
   input  logic        inst_ready,
   output logic        inst_sram_req,
   output logic        inst_sram_wr,
   output logic [1:0]  inst_sram_size,
   output logic [3:0]  inst_sram_wstrb,
   output logic [31:0] inst_sram_addr,
   output logic [31:0] inst_sram_wdata,
   input  logic        inst_sram_addr_ok,
   input  logic        inst_sram_data_ok,
   input  logic [31:0] inst_sram_rdata
);

   localparam int CW = $clog2(OST_MAX + 1);
   localparam int SW = CW + 2;
   localparam int PW = (OST_MAX > 1) ? $clog2(OST_MAX) : 1;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_DRAIN = 1'b1
   } state_e;

   state_e state_q, state_d;

   logic [CW-1:0] live_q, live_d;
   logic [CW-1:0] buf_q, buf_d;
   logic [CW-1:0] cancel_q, cancel_d;

   logic [PW-1:0] tag_wp_q, tag_wp_d;
   logic [PW-1:0] tag_rp_q, tag_rp_d;
   logic [PW-1:0] buf_wp_q, buf_wp_d;
   logic [PW-1:0] buf_rp_q, buf_rp_d;

   logic [31:0] tag_mem     [OST_MAX];
   logic [31:0] buf_pc_mem  [OST_MAX];
   logic [31:0] buf_dat_mem [OST_MAX];

   logic [SW-1:0] occ;
   logic          credit;
   logic          hs;
   logic          drain_mode;
   logic          drop;
   logic          take;
   logic          buf_wr;
   logic          pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(OST_MAX - 1)) begin
         return '0;
      end
      return p + PW'(1);
   endfunction

   // Every request that still owes a slot (live, buffered or owed a stale
   // return) holds one credit, so a returning word always finds buffer space.
   assign occ    = SW'(live_q) + SW'(buf_q) + SW'(cancel_q);
   assign credit = (occ < SW'(OST_MAX));

   // Held low while reset is asserted so the bus stays quiet even if preIF
   // keeps pc_req_valid high.
   assign inst_sram_req   = resetn & pc_req_valid & credit & ~flush;
   assign inst_sram_addr  = pc_req_addr;
   assign inst_sram_wr    = 1'b0;
   assign inst_sram_size  = 2'b10;
   assign inst_sram_wstrb = 4'b0000;
   assign inst_sram_wdata = 32'h0000_0000;

   assign hs           = inst_sram_req & inst_sram_addr_ok;
   assign pc_req_ready = hs;

   // Returns are in order: while stale data is still owed, every data_ok
   // belongs to a cancelled request and is discarded.
   assign drop   = inst_sram_data_ok & drain_mode;
   assign take   = inst_sram_data_ok & ~drain_mode;
   assign buf_wr = take & ~flush;

   assign inst_valid = (buf_q != '0);
   assign inst_pc    = buf_pc_mem[buf_rp_q];
   assign inst_rdata = buf_dat_mem[buf_rp_q];
   assign pop        = inst_valid & inst_ready & ~flush;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:   if (cancel_d != '0) state_d = ST_DRAIN;
         ST_DRAIN: if (cancel_d == '0) state_d = ST_RUN;
         default:  state_d = ST_RUN;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      drain_mode = 1'b0;
      case (state_q)
         ST_DRAIN: drain_mode = 1'b1;
         default:  drain_mode = 1'b0;
      endcase
   end

   // ---------------- counters ----------------
   always_comb begin
      live_d   = live_q;
      buf_d    = buf_q;
      cancel_d = cancel_q;
      if (flush) begin
         // Everything still in flight becomes owed; a return landing in the
         // flush cycle settles one of those debts whichever kind it is.
         live_d   = '0;
         buf_d    = '0;
         cancel_d = cancel_q + live_q - CW'(inst_sram_data_ok);
      end else begin
         live_d   = live_q + CW'(hs) - CW'(take);
         buf_d    = buf_q + CW'(take) - CW'(pop);
         cancel_d = cancel_q - CW'(drop);
      end
   end

   // ---------------- pointers ----------------
   always_comb begin
      tag_wp_d = tag_wp_q;
      tag_rp_d = tag_rp_q;
      buf_wp_d = buf_wp_q;
      buf_rp_d = buf_rp_q;
      if (flush) begin
         tag_wp_d = '0;
         tag_rp_d = '0;
         buf_wp_d = '0;
         buf_rp_d = '0;
      end else begin
         if (hs)   tag_wp_d = ptr_inc(tag_wp_q);
         if (take) tag_rp_d = ptr_inc(tag_rp_q);
         if (take) buf_wp_d = ptr_inc(buf_wp_q);
         if (pop)  buf_rp_d = ptr_inc(buf_rp_q);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         live_q   <= '0;
         buf_q    <= '0;
         cancel_q <= '0;
         tag_wp_q <= '0;
         tag_rp_q <= '0;
         buf_wp_q <= '0;
         buf_rp_q <= '0;
      end else begin
         live_q   <= live_d;
         buf_q    <= buf_d;
         cancel_q <= cancel_d;
         tag_wp_q <= tag_wp_d;
         tag_rp_q <= tag_rp_d;
         buf_wp_q <= buf_wp_d;
         buf_rp_q <= buf_rp_d;
      end
   end

   // ---------------- storage (no reset needed, guarded by counters) ----------------
   always_ff @(posedge clk) begin
      if (hs) begin
         tag_mem[tag_wp_q] <= pc_req_addr;
      end
      if (buf_wr) begin
         buf_pc_mem[buf_wp_q]  <= tag_mem[tag_rp_q];
         buf_dat_mem[buf_wp_q] <= inst_sram_rdata;
      end
   end

   // ---------------- invariants ----------------
   a_live_max : assert property (@(posedge clk) disable iff (!resetn)
      live_q <= CW'(OST_MAX));
   a_buf_max : assert property (@(posedge clk) disable iff (!resetn)
      buf_q <= CW'(OST_MAX));
   a_cancel_max : assert property (@(posedge clk) disable iff (!resetn)
      cancel_q <= CW'(OST_MAX));
   a_occ_max : assert property (@(posedge clk) disable iff (!resetn)
      occ <= SW'(OST_MAX));
   a_no_orphan_ret : assert property (@(posedge clk) disable iff (!resetn)
      !(take && live_q == '0));
   a_fsm_matches_cnt : assert property (@(posedge clk) disable iff (!resetn)
      drain_mode == (cancel_q != '0));

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: hand-written bus responses and expected values.
// Inputs are driven 1 time unit after the rising edge, outputs sampled 2 units later.
// The bus slave is played by the stimulus itself (addr_ok/data_ok per cycle).
module tb_inst_fetch_ctrl;

   logic        clk = 1'b0;
   logic        resetn;
   logic        pc_req_valid;
   logic [31:0] pc_req_addr;
   logic        pc_req_ready;
   logic        flush;
   logic        inst_valid;
   logic [31:0] inst_pc;
   logic [31:0] inst_rdata;
   logic        inst_ready;
   logic        inst_sram_req;
   logic        inst_sram_wr;
   logic [1:0]  inst_sram_size;
   logic [3:0]  inst_sram_wstrb;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic        inst_sram_addr_ok;
   logic        inst_sram_data_ok;
   logic [31:0] inst_sram_rdata;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   inst_fetch_ctrl #(.OST_MAX(2)) dut (
      .clk               (clk),
      .resetn            (resetn),
      .pc_req_valid      (pc_req_valid),
      .pc_req_addr       (pc_req_addr),
      .pc_req_ready      (pc_req_ready),
      .flush             (flush),
      .inst_valid        (inst_valid),
      .inst_pc           (inst_pc),
      .inst_rdata        (inst_rdata),
      .inst_ready        (inst_ready),
      .inst_sram_req     (inst_sram_req),
      .inst_sram_wr      (inst_sram_wr),
      .inst_sram_size    (inst_sram_size),
      .inst_sram_wstrb   (inst_sram_wstrb),
      .inst_sram_addr    (inst_sram_addr),
      .inst_sram_wdata   (inst_sram_wdata),
      .inst_sram_addr_ok (inst_sram_addr_ok),
      .inst_sram_data_ok (inst_sram_data_ok),
      .inst_sram_rdata   (inst_sram_rdata)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive this cycle's inputs just after the edge, then let
   // combinational outputs settle before the caller samples them.
   task automatic cyc(input logic pv, input logic [31:0] pa, input logic aok,
                      input logic dok, input logic [31:0] rd, input logic irdy,
                      input logic fl);
      @(posedge clk);
      #1;
      pc_req_valid      = pv;
      pc_req_addr       = pa;
      inst_sram_addr_ok = aok;
      inst_sram_data_ok = dok;
      inst_sram_rdata   = rd;
      inst_ready        = irdy;
      flush             = fl;
      #2;
   endtask

   task automatic idle();
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [5:0]  t2_exp_req;
      logic [31:0] t2_pc;
      int          t2_hs;

      resetn            = 1'b0;
      pc_req_valid      = 1'b1;
      pc_req_addr       = 32'h1C00_0000;
      flush             = 1'b0;
      inst_ready        = 1'b0;
      inst_sram_addr_ok = 1'b1;
      inst_sram_data_ok = 1'b0;
      inst_sram_rdata   = 32'h0;

      // ---- reset state ----
      #3;
      check("rst_inst_valid", 32'(inst_valid), 32'd0);
      check("rst_req", 32'(inst_sram_req), 32'd0);
      check("rst_pc_req_ready", 32'(pc_req_ready), 32'd0);
      #20;
      pc_req_valid = 1'b0;
      inst_sram_addr_ok = 1'b0;
      resetn = 1'b1;

      // ---- 1: back-to-back fetch, data one cycle later ----
      cyc(1'b1, 32'h1C00_0000, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      check("t1_req", 32'(inst_sram_req), 32'd1);
      check("t1_ready0", 32'(pc_req_ready), 32'd1);
      check("t1_addr0", inst_sram_addr, 32'h1C00_0000);
      check("t1_wr", 32'(inst_sram_wr), 32'd0);
      check("t1_size", 32'(inst_sram_size), 32'd2);
      check("t1_wstrb", 32'(inst_sram_wstrb), 32'd0);
      check("t1_wdata", inst_sram_wdata, 32'd0);
      cyc(1'b1, 32'h1C00_0004, 1'b1, 1'b1, 32'h1111_1111, 1'b1, 1'b0);
      check("t1_ready1", 32'(pc_req_ready), 32'd1);
      check("t1_no_bypass", 32'(inst_valid), 32'd0);
      cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h2222_2222, 1'b1, 1'b0);
      check("t1_valid0", 32'(inst_valid), 32'd1);
      check("t1_pc0", inst_pc, 32'h1C00_0000);
      check("t1_rdata0", inst_rdata, 32'h1111_1111);
      idle();
      inst_ready = 1'b1;
      #1;
      check("t1_valid1", 32'(inst_valid), 32'd1);
      check("t1_pc1", inst_pc, 32'h1C00_0004);
      check("t1_rdata1", inst_rdata, 32'h2222_2222);
      idle();
      check("t1_empty", 32'(inst_valid), 32'd0);

      // ---- 2: credit exhaustion with IF stalled ----
      t2_exp_req = 6'b100011;
      t2_pc      = 32'h1C00_0010;
      t2_hs      = 0;
      for (int c = 0; c < 6; c++) begin
         cyc(1'b1, t2_pc, 1'b1, (c == 1 || c == 2), 32'hA000_0000 + 32'(c), (c == 4), 1'b0);
         check($sformatf("t2_req_c%0d", c), 32'(inst_sram_req), 32'(t2_exp_req[c]));
         if (c == 4) begin
            check("t2_head_pc", inst_pc, 32'h1C00_0010);
            check("t2_head_rdata", inst_rdata, 32'hA000_0001);
         end
         if (pc_req_ready) begin
            t2_hs++;
            t2_pc = t2_pc + 32'd4;
         end
      end
      cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'hA000_0006, 1'b1, 1'b0);
      check("t2_pc1", inst_pc, 32'h1C00_0014);
      check("t2_rdata1", inst_rdata, 32'hA000_0002);
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      check("t2_pc2", inst_pc, 32'h1C00_0018);
      check("t2_rdata2", inst_rdata, 32'hA000_0006);
      idle();
      check("t2_empty", 32'(inst_valid), 32'd0);
      check("t2_handshakes", 32'(t2_hs), 32'd3);

      // ---- 3: flush with two live requests, stale returns dropped ----
      cyc(1'b1, 32'h1C00_0020, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      cyc(1'b1, 32'h1C00_0024, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      cyc(1'b1, 32'h1C00_0100, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      check("t3_req_in_flush", 32'(inst_sram_req), 32'd0);
      check("t3_ready_in_flush", 32'(pc_req_ready), 32'd0);
      cyc(1'b1, 32'h1C00_0100, 1'b1, 1'b1, 32'hDEAD_0001, 1'b0, 1'b0);
      check("t3_req_no_credit", 32'(inst_sram_req), 32'd0);
      check("t3_stale1_valid", 32'(inst_valid), 32'd0);
      cyc(1'b1, 32'h1C00_0100, 1'b1, 1'b1, 32'hDEAD_0002, 1'b0, 1'b0);
      check("t3_req_in_drain", 32'(inst_sram_req), 32'd1);
      check("t3_stale2_valid", 32'(inst_valid), 32'd0);
      cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0123, 1'b0, 1'b0);
      check("t3_after_drop_valid", 32'(inst_valid), 32'd0);
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      check("t3_new_valid", 32'(inst_valid), 32'd1);
      check("t3_new_pc", inst_pc, 32'h1C00_0100);
      check("t3_new_rdata", inst_rdata, 32'h0000_0123);
      idle();
      check("t3_empty", 32'(inst_valid), 32'd0);

      // ---- 4: flush coincident with data_ok (1 live + 1 buffered) ----
      cyc(1'b1, 32'h1C00_0030, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      cyc(1'b1, 32'h1C00_0034, 1'b1, 1'b1, 32'h0000_00B0, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_00B1, 1'b1, 1'b1);
      check("t4_buffered_before_flush", 32'(inst_valid), 32'd1);
      check("t4_req_in_flush", 32'(inst_sram_req), 32'd0);
      cyc(1'b1, 32'h1C00_0200, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      check("t4_flushed_empty", 32'(inst_valid), 32'd0);
      check("t4_req_after", 32'(inst_sram_req), 32'd1);
      cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_C0DE, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      check("t4_new_valid", 32'(inst_valid), 32'd1);
      check("t4_new_pc", inst_pc, 32'h1C00_0200);
      check("t4_new_rdata", inst_rdata, 32'h0000_C0DE);
      idle();
      check("t4_empty", 32'(inst_valid), 32'd0);

      // ---- 5: addr_ok withheld for three cycles ----
      for (int c = 0; c < 3; c++) begin
         cyc(1'b1, 32'h1C00_0040, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
         check($sformatf("t5_req_c%0d", c), 32'(inst_sram_req), 32'd1);
         check($sformatf("t5_addr_c%0d", c), inst_sram_addr, 32'h1C00_0040);
         check($sformatf("t5_ready_c%0d", c), 32'(pc_req_ready), 32'd0);
      end
      cyc(1'b1, 32'h1C00_0040, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      check("t5_ready_accept", 32'(pc_req_ready), 32'd1);
      cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0055, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      check("t5_pc", inst_pc, 32'h1C00_0040);
      check("t5_rdata", inst_rdata, 32'h0000_0055);
      idle();
      check("t5_empty", 32'(inst_valid), 32'd0);

      // ---- 6: reset mid-transfer ----
      cyc(1'b1, 32'h1C00_0050, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      cyc(1'b1, 32'h1C00_0054, 1'b1, 1'b1, 32'h0000_0066, 1'b0, 1'b0);
      cyc(1'b1, 32'h1C00_0058, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      check("t6_valid_before", 32'(inst_valid), 32'd1);
      #1;
      resetn = 1'b0;
      #1;
      check("t6_valid_in_rst", 32'(inst_valid), 32'd0);
      check("t6_req_in_rst", 32'(inst_sram_req), 32'd0);
      check("t6_ready_in_rst", 32'(pc_req_ready), 32'd0);
      @(posedge clk);
      #3;
      pc_req_valid = 1'b0;
      resetn = 1'b1;
      #1;
      check("t6_valid_after_rst", 32'(inst_valid), 32'd0);
      cyc(1'b1, 32'h1C00_0000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      check("t6_ready", 32'(pc_req_ready), 32'd1);
      cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0077, 1'b0, 1'b0);
      check("t6_no_bypass", 32'(inst_valid), 32'd0);
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      check("t6_valid", 32'(inst_valid), 32'd1);
      check("t6_pc", inst_pc, 32'h1C00_0000);
      check("t6_rdata", inst_rdata, 32'h0000_0077);
      idle();
      check("t6_empty", 32'(inst_valid), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
